// File: rtl/jt6295_pkg.sv
// Shared constants for the OKI MSM6295-style ADPCM decoder.
// Holds the datapath widths, the 49-entry step table, the index
// adjustment table and the attenuation gain table.
package jt6295_pkg;

  localparam int SIGW  = 12;  // decoded signal width (signed)
  localparam int IDXW  = 6;   // step index width (0..48)
  localparam int OUTW  = 14;  // mixed output width (signed)
  localparam int STEPW = 12;  // step / diff width (unsigned)
  localparam int IDX_MAX = 48;

  localparam logic [STEPW-1:0] STEP [0:48] = '{
    12'd16,   12'd17,   12'd19,   12'd21,   12'd23,   12'd25,   12'd28,
    12'd31,   12'd34,   12'd37,   12'd41,   12'd45,   12'd50,   12'd55,
    12'd60,   12'd66,   12'd73,   12'd80,   12'd88,   12'd97,   12'd107,
    12'd118,  12'd130,  12'd143,  12'd157,  12'd173,  12'd190,  12'd209,
    12'd230,  12'd253,  12'd279,  12'd307,  12'd337,  12'd371,  12'd408,
    12'd449,  12'd494,  12'd544,  12'd598,  12'd658,  12'd724,  12'd796,
    12'd876,  12'd963,  12'd1060, 12'd1166, 12'd1282, 12'd1411, 12'd1552
  };

  localparam logic signed [4:0] ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8
  };

  // Gain in 1/32 units; codes 9..15 mute the channel.
  localparam logic [5:0] GAIN [0:15] = '{
    6'd32, 6'd22, 6'd16, 6'd11, 6'd8, 6'd6, 6'd4, 6'd3,
    6'd2,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0
  };

endpackage

// File: rtl/jt6295_adpcm_ring.sv
// Circulating per-channel state store: a STAGES-deep shift register
// advanced on each clock enable. The value written at one enabled edge
// reappears on q exactly STAGES enabled edges later.
// Ports: clk, rst (sync, active-high), cen (advance), d (write), q (read).
module jt6295_adpcm_ring #(
  parameter int WIDTH  = 18,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [0:STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          stage_reg[gi] <= '0;
        end else if (cen) begin
          if (gi == 0) stage_reg[gi] <= d;
          else         stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/jt6295_adpcm_dec.sv
// Four-channel time-multiplexed OKI ADPCM decoder and mixer.
// One channel slot is processed per cen4 pulse: the channel's state is
// read from the ring, decoded with the incoming nibble, written back,
// attenuated and accumulated. The slot-3 edge publishes the frame mix.
// Ports: clk, rst (sync, active-high), cen4 (slot enable), first (slot 0
// marker), en (channel active), att (attenuation code), data (nibble),
// sound (signed 14-bit mix), sample (one-clk pulse on sound update).
module jt6295_adpcm_dec
  import jt6295_pkg::*;
#(
  parameter int CLR_IDLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen4,
  input  logic                   first,
  input  logic                   en,
  input  logic [3:0]             att,
  input  logic [3:0]             data,
  output logic signed [OUTW-1:0] sound,
  output logic                   sample
);

  localparam int RW = SIGW + IDXW;

  logic [1:0]             slot_reg;
  logic                   synced_reg;   // a first marker has been seen since reset
  logic signed [OUTW-1:0] acc_reg;
  logic signed [OUTW-1:0] sound_reg;
  logic                   sample_reg;

  logic [RW-1:0]          ring_q;
  logic [RW-1:0]          ring_d;
  logic [1:0]             cur_slot;
  logic signed [SIGW-1:0] sig_cur;
  logic [IDXW-1:0]        idx_cur;
  logic [STEPW-1:0]       step;
  logic [STEPW-1:0]       diff;
  logic signed [OUTW-1:0] sum;
  logic signed [SIGW-1:0] sig_next;
  logic signed [7:0]      idx_sum;
  logic [IDXW-1:0]        idx_next;
  logic signed [SIGW-1:0] mix_sig;
  logic signed [18:0]     prod;
  logic signed [OUTW-1:0] contrib;

  jt6295_adpcm_ring #(.WIDTH(RW), .STAGES(4)) u_ring (
    .clk (clk),
    .rst (rst),
    .cen (cen4),
    .d   (ring_d),
    .q   (ring_q)
  );

  // first marks channel 0 directly, so the slot counter is bypassed.
  assign cur_slot = first ? 2'd0 : slot_reg;
  assign sig_cur  = ring_q[RW-1:IDXW];
  assign idx_cur  = ring_q[IDXW-1:0];

  always_comb begin
    step = STEP[idx_cur];
    diff = (step >> 3)
         + (data[2] ? step        : '0)
         + (data[1] ? (step >> 1) : '0)
         + (data[0] ? (step >> 2) : '0);

    if (data[3]) sum = {{2{sig_cur[SIGW-1]}}, sig_cur} - $signed({2'b00, diff});
    else         sum = {{2{sig_cur[SIGW-1]}}, sig_cur} + $signed({2'b00, diff});

    if (sum > 14'sd2047)       sig_next = 12'sd2047;
    else if (sum < -14'sd2048) sig_next = -12'sd2048;
    else                       sig_next = sum[SIGW-1:0];

    idx_sum = $signed({2'b00, idx_cur}) + {{3{ADJ[data[2:0]][4]}}, ADJ[data[2:0]]};
    if (idx_sum < 8'sd0)            idx_next = '0;
    else if (idx_sum > 8'sd48)      idx_next = IDXW'(IDX_MAX);
    else                            idx_next = idx_sum[IDXW-1:0];

    if (en)                ring_d = {sig_next, idx_next};
    else if (CLR_IDLE != 0) ring_d = '0;
    else                   ring_d = ring_q;

    mix_sig = en ? sig_next : '0;
    prod    = $signed({{7{mix_sig[SIGW-1]}}, mix_sig}) * $signed({13'b0, GAIN[att]});
    contrib = OUTW'(prod >>> 5);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg   <= '0;
      synced_reg <= 1'b0;
      acc_reg    <= '0;
      sound_reg  <= '0;
      sample_reg <= 1'b0;
    end else begin
      sample_reg <= 1'b0;
      if (cen4) begin
        slot_reg <= first ? 2'd1 : slot_reg + 2'd1;
        if (first) synced_reg <= 1'b1;
        case (cur_slot)
          2'd0: acc_reg <= contrib;   // also drops a partial frame on resync
          2'd3: begin
            acc_reg <= '0;
            // Frames not started by a first marker after reset are discarded.
            if (synced_reg) begin
              sound_reg  <= acc_reg + contrib;
              sample_reg <= 1'b1;
            end
          end
          default: acc_reg <= acc_reg + contrib;
        endcase
      end
    end
  end

  assign sound  = sound_reg;
  assign sample = sample_reg;

endmodule

// File: tb/tb_jt6295_adpcm_dec.sv
module tb_jt6295_adpcm_dec;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cen4 = 1'b0;
  logic               first = 1'b0;
  logic               en = 1'b0;
  logic [3:0]         att = 4'd0;
  logic [3:0]         data = 4'd0;
  logic signed [13:0] sound;
  logic               sample;

  int n_tests = 0;
  int n_fail  = 0;

  jt6295_adpcm_dec #(.CLR_IDLE(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .cen4   (cen4),
    .first  (first),
    .en     (en),
    .att    (att),
    .data   (data),
    .sound  (sound),
    .sample (sample)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int step_t [0:48] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,
                        88,97,107,118,130,143,157,173,190,209,230,253,279,307,
                        337,371,408,449,494,544,598,658,724,796,876,963,1060,
                        1166,1282,1411,1552};
  int adj_t  [0:7]  = '{-1,-1,-1,-1,2,4,6,8};
  int gain_t [0:15] = '{32,22,16,11,8,6,4,3,2,0,0,0,0,0,0,0};

  int m_sig [0:3];
  int m_idx [0:3];
  int m_pos, m_slot, m_acc, m_sound;
  bit m_synced, exp_sample;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_sig[i] = 0; m_idx[i] = 0; end
    m_pos = 0; m_slot = 0; m_acc = 0; m_sound = 0;
    m_synced = 1'b0; exp_sample = 1'b0;
  endtask

  task automatic model_slot(input bit f, input bit e, input int a, input int d);
    int cur, s, ix, st, df, c;
    cur = f ? 0 : m_slot;
    s  = m_sig[m_pos];
    ix = m_idx[m_pos];
    c  = 0;
    if (e) begin
      st = step_t[ix];
      df = st / 8 + ((d & 4) != 0 ? st : 0) + ((d & 2) != 0 ? st / 2 : 0)
         + ((d & 1) != 0 ? st / 4 : 0);
      s = ((d & 8) != 0) ? s - df : s + df;
      if (s > 2047)  s = 2047;
      if (s < -2048) s = -2048;
      ix = ix + adj_t[d & 7];
      if (ix < 0)  ix = 0;
      if (ix > 48) ix = 48;
      m_sig[m_pos] = s;
      m_idx[m_pos] = ix;
      c = (s * gain_t[a]) >>> 5;
    end else begin
      m_sig[m_pos] = 0;
      m_idx[m_pos] = 0;
    end
    exp_sample = 1'b0;
    if (cur == 0) m_acc = c;
    else if (cur == 3) begin
      if (m_synced) begin
        m_sound = m_acc + c;
        exp_sample = 1'b1;
      end
      m_acc = 0;
    end else m_acc = m_acc + c;
    if (f) m_synced = 1'b1;
    m_slot = f ? 1 : (m_slot + 1) % 4;
    m_pos  = (m_pos + 1) % 4;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_slot(input bit f, input bit e, input int a, input int d,
                         input int gap);
    logic signed [13:0] exp_sound;
    model_slot(f, e, a, d);
    first = f; en = e; att = a[3:0]; data = d[3:0];
    cen4 = 1'b1;
    @(posedge clk); #1;
    cen4 = 1'b0;
    exp_sound = 14'(m_sound);
    n_tests++;
    if (sample !== exp_sample) begin
      n_fail++;
      $display("FAIL sample: got %0b expected %0b", sample, exp_sample);
    end
    n_tests++;
    if (sound !== exp_sound) begin
      n_fail++;
      $display("FAIL sound: got %0d expected %0d", sound, exp_sound);
    end
    $display("[TB] slot f=%0b en=%0b att=%0d data=%0d -> sound=%0d sample=%0b",
             f, e, a, d, sound, sample);
    // Idle clocks without cen4: everything must stay frozen.
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      n_tests++;
      if (sample !== 1'b0 || sound !== exp_sound) begin
        n_fail++;
        $display("FAIL freeze: got sound=%0d sample=%0b expected sound=%0d sample=0",
                 sound, sample, exp_sound);
      end
    end
  endtask

  // ch0 active with given att/data, channels 1..3 idle
  task automatic frame_ch0(input int a, input int d);
    do_slot(1'b1, 1'b1, a, d, 0);
    for (int s = 1; s < 4; s++) do_slot(1'b0, 1'b0, 0, 0, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1; cen4 = 1'b0; first = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_sound(input logic signed [13:0] want, input string name);
    n_tests++;
    if (sound !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, sound, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cen4 = 1'b1;  // reset must win even with cen4 high
    apply_reset();
    n_tests++;
    if (sound !== 14'sd0 || sample !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got sound=%0d sample=%0b expected 0/0", sound, sample);
    end
    $display("[TB] reset -> sound=%0d sample=%0b", sound, sample);
  endtask

  task automatic test_basic();
    apply_reset();
    frame_ch0(0, 7);
    check_sound(14'sd30, "first_frame");
    frame_ch0(0, 7);
    check_sound(14'sd93, "second_frame");
  endtask

  task automatic test_negative();
    apply_reset();
    frame_ch0(0, 8);
    check_sound(-14'sd2, "neg_step");
    frame_ch0(0, 7);  // index stayed at 0 -> diff 30
    check_sound(14'sd28, "index_low_sat");
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int fr = 0; fr < 16; fr++)
      for (int s = 0; s < 4; s++) do_slot(s == 0, 1'b1, 0, 7, 0);
    check_sound(14'sd8188, "saturate");
  endtask

  task automatic test_att_idle();
    apply_reset();
    frame_ch0(2, 7);
    check_sound(14'sd15, "att2");
    frame_ch0(12, 7);
    check_sound(14'sd0, "att12");
    frame_ch0(0, 0);
    do_slot(1'b1, 1'b0, 0, 7, 0);  // ch0 dropped
    for (int s = 1; s < 4; s++) do_slot(1'b0, 1'b0, 0, 0, 0);
    check_sound(14'sd0, "en_drop");
    frame_ch0(0, 7);
    check_sound(14'sd30, "restart");
  endtask

  task automatic test_resync();
    apply_reset();
    frame_ch0(0, 7);
    do_slot(1'b1, 1'b1, 0, 7, 0);
    do_slot(1'b0, 1'b0, 0, 0, 0);
    do_slot(1'b1, 1'b1, 0, 1, 0);  // first arrives at slot 2
    for (int s = 1; s < 4; s++) do_slot(1'b0, 1'b1, 0, 2, 0);
    // mid-frame reset
    do_slot(1'b1, 1'b1, 0, 7, 0);
    do_slot(1'b0, 1'b1, 0, 7, 0);
    apply_reset();
    check_sound(14'sd0, "rst_midframe");
    for (int s = 0; s < 4; s++) do_slot(1'b0, 1'b1, 0, 7, 0);
    check_sound(14'sd0, "no_sync_after_rst");
    frame_ch0(0, 7);
  endtask

  task automatic test_random();
    apply_reset();
    for (int fr = 0; fr < 40; fr++)
      for (int s = 0; s < 4; s++)
        do_slot((s == 0) || ($urandom_range(0, 19) == 0),
                $urandom_range(0, 7) != 0,
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)));
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_negative();
    test_saturate();
    test_att_idle();
    test_resync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jt6295_adpcm_dec.md
JT6295_ADPCM_DEC -- requirements
Module: jt6295_adpcm_dec

Interface
REQ-001 SHALL have parameter CLR_IDLE, default 1, meaning: 1 = channel state cleared while en low; 0 = state held.
REQ-002 SHALL have port: clk  input  1  system clock; single clock domain.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: cen4  input  1  channel-slot enable; one channel processed per cen4 pulse.
REQ-005 SHALL have port: first  input  1  high on the slot carrying channel 0 nibble.
REQ-006 SHALL have port: en  input  1  channel active (serializer pipe enable).
REQ-007 SHALL have port: att  input  4  attenuation code for the slot's channel.
REQ-008 SHALL have port: data  input  4  ADPCM nibble for the slot's channel (bit3 = sign).
REQ-009 SHALL have port: sound  output  14  signed mix of four channels.
REQ-010 SHALL have port: sample  output  1  one-clk pulse when sound updates.

Function
REQ-011 SHALL process inputs only on clk edges with cen4=1; all state frozen otherwise.
REQ-012 SHALL keep per-channel state: signal (12-bit signed) and step index (6-bit, 0..48), circulating through a 4-stage register advanced on cen4.
REQ-013 SHALL track slot with a 2-bit counter: slot := 1 after a cen4 edge with first=1, else slot+1; first=1 mid-frame resyncs to slot 0 and discards the accumulator.
REQ-014 SHALL look up step = STEP[index] (standard OKI 49-entry table, 16..1552).
REQ-015 SHALL form diff = step>>3 + (data[2]?step:0) + (data[1]?step>>1:0) + (data[0]?step>>2:0), unsigned 12-bit.
REQ-016 SHALL compute new signal = signal -/+ diff (minus when data[3]=1), saturated to -2048..+2047.
REQ-017 SHALL update index += ADJ[data[2:0]], ADJ = {-1,-1,-1,-1,2,4,6,8}, saturated to 0..48.
REQ-018 SHALL, when en=0 on a slot, write back signal=0/index=0 if CLR_IDLE=1, else unchanged; contribution = 0.
REQ-019 SHALL attenuate: contrib = (signal*GAIN[att])>>>5, GAIN = {32,22,16,11,8,6,4,3,2} for att 0..8; att 9..15 gives 0; arithmetic shift.
REQ-020 SHALL accumulate contributions of slots 0..2; on slot-3 edge: sound <= acc + contrib3, acc <= 0, sample=1 for that one clk.
REQ-021 SHALL use updated signal (same edge) for contribution: nibble in slot n affects sound at the slot-3 edge of the same frame.
REQ-022 SHALL guarantee no overflow: 4 x 12-bit fits 14 bits signed.

Reset
REQ-023 SHALL on rst clear all channel signals and indices, accumulator, slot counter to 0; sound=0, sample=0.
REQ-024 SHALL honour rst regardless of cen4; rst mid-frame abandons the frame, no sample pulse until a full new frame after first.

Structure
REQ-025 SHALL place STEP table, ADJ table, GAIN table and widths (SIGW=12, IDXW=6, OUTW=14) in shared package jt6295_pkg.
REQ-026 SHALL implement the per-channel state ring as sub-module jt6295_adpcm_ring (WIDTH=18, STAGES=4, sync reset, clock enable).
REQ-027 SHALL keep decode, attenuation and mix combinational within one slot; all registers enabled by cen4 except sample.

Verification
REQ-028 SHALL cover: reset, ch0 en=1 att=0 data=7, others en=0 -> sound=30 at slot-3 edge; ch0 index=8.
REQ-029 SHALL cover: next frame ch0 data=7 -> step 34, diff 63, sound=93, index 16.
REQ-030 SHALL cover: ch0 data=8 from reset -> sound=-2, index 0 (saturated low).
REQ-031 SHALL cover: repeated data=7 on all four channels until saturation -> each signal 2047, sound=8188, no wrap.
REQ-032 SHALL cover: ch0 signal 30, att=2 -> contrib 15; att=12 -> 0; en drop -> state cleared, next start begins at 16 step.
REQ-033 SHALL cover: first asserted at slot 2 -> no sample that frame, resync; rst mid-frame -> sound=0, sample silent.
